main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: op  in  7  opcode field of the held instruction register.
REQ-005 Port: zero  in  1  ALU zero flag, used for branch resolution.
REQ-006 Port: mem_ready  in  1  memory handshake: the access in progress completes this cycle.
REQ-007 Outputs, each 1 bit: pc_write, adr_src (0 = PC, 1 = result), mem_write, ir_write, reg_write, illegal_instr.
REQ-008 Outputs, each 2 bits: result_src (00 = ALUOut, 01 = Data, 10 = ALUResult), alu_src_a (00 = PC, 01 = OldPC, 10 = RD1), alu_src_b (00 = RD2, 01 = ImmExt, 10 = const 4), alu_op (00 = add, 01 = sub/branch, 10 = funct-decoded).

Function
REQ-009 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL.
REQ-010 Every output not listed for a state SHALL be 0.
REQ-011 pc_write SHALL equal pc_update OR (branch AND zero), where pc_update and branch are internal signals.
REQ-012 FETCH outputs: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. When mem_ready=1, ir_write=1, pc_update=1 and the next state is DECODE. When mem_ready=0, ir_write and pc_update are 0 and the state holds.
REQ-013 DECODE outputs: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
REQ-014 In DECODE, any other opcode SHALL assert illegal_instr for exactly one cycle and return to FETCH with no register or memory write.
REQ-015 MEMADR outputs: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD when op=0000011, else MEMWRITE.
REQ-016 MEMREAD outputs: result_src=00, adr_src=1. The state holds until mem_ready=1, then goes to MEMWB.
REQ-017 MEMWB outputs: result_src=01, reg_write=1. Next state is FETCH.
REQ-018 MEMWRITE outputs: result_src=00, adr_src=1, mem_write=1. mem_write stays asserted while waiting; the state goes to FETCH in the cycle mem_ready=1.
REQ-019 EXECUTER outputs: alu_src_a=10, alu_src_b=00, alu_op=10. Next state is ALUWB.
REQ-020 EXECUTEI outputs: alu_src_a=10, alu_src_b=01, alu_op=10. Next state is ALUWB.
REQ-021 ALUWB outputs: result_src=00, reg_write=1. Next state is FETCH.
REQ-022 BEQ outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next state is FETCH.
REQ-023 JAL outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next state is ALUWB.
REQ-024 Latency without memory wait: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4, illegal 2.
REQ-025 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.

Reset
REQ-026 While rst_n=0, the state SHALL be FETCH, and pc_write, ir_write, mem_write, reg_write and illegal_instr SHALL all be 0 regardless of mem_ready.
REQ-027 Reset asserted mid-instruction, including MEMWRITE with mem_ready=0, SHALL abort immediately; the block then restarts with FETCH on the first clock edge after rst_n rises.

Structure
REQ-028 The state enum, opcode constants, alu_op encodings and the source-select encodings SHALL be defined in the shared riscv_pkg.
REQ-029 The block SHALL have no sub-modules; its alu_op output connects directly to the existing ALU decoder.
REQ-030 Next-state logic and output logic SHALL be separate combinational processes, with a single state register.

Verification
REQ-031 R-type: op=0110011, mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH; alu_op=10 in EXECUTER; reg_write=1 only in ALUWB.
REQ-032 lw with wait: op=0000011, mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with adr_src=1; MEMWB follows with result_src=01 and reg_write=1.
REQ-033 beq: op=1100011 with zero=1 -> pc_write=1 in BEQ. With zero=0 -> pc_write=0; both return to FETCH.
REQ-034 jal: op=1101111 -> pc_write=1 and alu_src_b=10 in JAL, then ALUWB with reg_write=1.
REQ-035 Illegal opcode: op=1111111 -> illegal_instr=1 for one cycle in DECODE, next state FETCH, no write enables asserted.
REQ-036 Reset mid-store: drop rst_n in MEMWRITE with mem_ready=0 -> mem_write=0 within the same cycle; after release, FETCH with ir_write=1 once mem_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared multicycle RISC-V control encodings: FSM states, opcodes, ALU op and
// datapath source-select values.
package riscv_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] ResultAluOut    = 2'b00;
  localparam logic [1:0] ResultData      = 2'b01;
  localparam logic [1:0] ResultAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic AdrPc     = 1'b0;
  localparam logic AdrResult = 1'b1;

endpackage

// File: rtl/main_fsm.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch, decode,
// memory, execute and writeback steps and drives the datapath selects.
module main_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op
);

  state_e r_state;
  state_e w_state_next;
  logic   w_pc_update;
  logic   w_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StFetch;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:    if (mem_ready) w_state_next = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: w_state_next = StMemAdr;
          OpRtype:         w_state_next = StExecuteR;
          OpItype:         w_state_next = StExecuteI;
          OpBranch:        w_state_next = StBeq;
          OpJal:           w_state_next = StJal;
          default:         w_state_next = StFetch;
        endcase
      end
      StMemAdr:   w_state_next = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) w_state_next = StMemWb;
      StMemWb:    w_state_next = StFetch;
      StMemWrite: if (mem_ready) w_state_next = StFetch;
      StExecuteR: w_state_next = StAluWb;
      StExecuteI: w_state_next = StAluWb;
      StAluWb:    w_state_next = StFetch;
      StBeq:      w_state_next = StFetch;
      StJal:      w_state_next = StAluWb;
      default:    w_state_next = StFetch;
    endcase
  end

  always_comb begin
    adr_src       = AdrPc;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    result_src    = ResultAluOut;
    alu_src_a     = SrcAPc;
    alu_src_b     = SrcBRd2;
    alu_op        = AluOpAdd;
    w_pc_update   = 1'b0;
    w_branch      = 1'b0;
    case (r_state)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResultAluResult;
        // Reset forces FETCH, so the only enables to mask are the mem_ready ones.
        ir_write    = mem_ready & rst_n;
        w_pc_update = mem_ready & rst_n;
      end
      StDecode: begin
        alu_src_a     = SrcAOldPc;
        alu_src_b     = SrcBImm;
        illegal_instr = !(op inside {OpLoad, OpStore, OpRtype, OpItype, OpBranch, OpJal});
      end
      StMemAdr: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBImm;
      end
      StMemRead:  adr_src = AdrResult;
      StMemWb: begin
        result_src = ResultData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = AdrResult;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcARd1;
        alu_op    = AluOpFunct;
      end
      StExecuteI: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb:    reg_write = 1'b1;
      StBeq: begin
        alu_src_a = SrcARd1;
        alu_op    = AluOpSub;
        w_branch  = 1'b1;
      end
      StJal: begin
        alu_src_a   = SrcAOldPc;
        alu_src_b   = SrcBFour;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write = w_pc_update | (w_branch & zero);

endmodule

// File: tb/tb_main_fsm.sv
// Randomized bench for main_fsm: per-instruction expected step traces are built
// from the instruction class and wait counts, then replayed cycle by cycle.
module tb_main_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct {
    int   kind;
    logic mr;
    logic z;
    bit   live;
  } rec_t;

  localparam int KFetch = 0, KDecode = 1, KIllegal = 2, KMemAdr = 3, KMemRead = 4;
  localparam int KMemWb = 5, KMemWrite = 6, KExecR = 7, KExecI = 8, KAluWb = 9;
  localparam int KBeq = 10, KJal = 11;

  localparam logic [6:0] TLoad = 7'b0000011, TStore = 7'b0100011, TRtype = 7'b0110011;
  localparam logic [6:0] TItype = 7'b0010011, TBranch = 7'b1100011, TJal = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  ctrl_t      act;

  int checks = 0;
  int failures = 0;

  main_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .illegal_instr (illegal_instr),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
                result_src, alu_src_a, alu_src_b, alu_op};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic string kind_name(input int k);
    case (k)
      KFetch:    return "fetch";
      KDecode:   return "decode";
      KIllegal:  return "decode_illegal";
      KMemAdr:   return "memadr";
      KMemRead:  return "memread";
      KMemWb:    return "memwb";
      KMemWrite: return "memwrite";
      KExecR:    return "execute_r";
      KExecI:    return "execute_i";
      KAluWb:    return "aluwb";
      KBeq:      return "beq";
      KJal:      return "jal";
      default:   return "unknown";
    endcase
  endfunction

  // Expected control word for one step, straight from the per-step output table.
  function automatic ctrl_t exp_ctrl(input int k, input logic mr, input logic z);
    ctrl_t c;
    c = '0;
    case (k)
      KFetch: begin
        c.alu_src_b = 2'b10; c.result_src = 2'b10; c.ir_write = mr; c.pc_write = mr;
      end
      KDecode:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      KIllegal:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.illegal = 1'b1; end
      KMemAdr:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      KMemRead:  c.adr_src = 1'b1;
      KMemWb:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      KMemWrite: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      KExecR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      KExecI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      KAluWb:    c.reg_write = 1'b1;
      KBeq:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_write = z; end
      KJal:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic rec_t mk(input int k, input logic mr, input logic z, input bit live);
    rec_t r;
    r.kind = k; r.mr = mr; r.z = z; r.live = live;
    return r;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Builds the step trace of one instruction and replays up to limit steps (-1 = all).
  // op is only driven with the real opcode in the steps that sample it.
  task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input logic z,
                           input int limit);
    rec_t q[$];
    bit   legal;
    legal = o inside {TLoad, TStore, TRtype, TItype, TBranch, TJal};
    for (int i = 0; i < fw; i++) q.push_back(mk(KFetch, 1'b0, rbit(), 1'b0));
    q.push_back(mk(KFetch, 1'b1, rbit(), 1'b0));
    q.push_back(mk(legal ? KDecode : KIllegal, rbit(), rbit(), 1'b1));
    if (o == TLoad || o == TStore) begin
      q.push_back(mk(KMemAdr, rbit(), rbit(), 1'b1));
      for (int i = 0; i < mw; i++)
        q.push_back(mk(o == TLoad ? KMemRead : KMemWrite, 1'b0, rbit(), 1'b0));
      q.push_back(mk(o == TLoad ? KMemRead : KMemWrite, 1'b1, rbit(), 1'b0));
      if (o == TLoad) q.push_back(mk(KMemWb, rbit(), rbit(), 1'b0));
    end else if (o == TRtype || o == TItype) begin
      q.push_back(mk(o == TRtype ? KExecR : KExecI, rbit(), rbit(), 1'b0));
      q.push_back(mk(KAluWb, rbit(), rbit(), 1'b0));
    end else if (o == TBranch) begin
      q.push_back(mk(KBeq, rbit(), z, 1'b0));
    end else if (o == TJal) begin
      q.push_back(mk(KJal, rbit(), rbit(), 1'b0));
      q.push_back(mk(KAluWb, rbit(), rbit(), 1'b0));
    end
    for (int i = 0; i < q.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      @(negedge clk);
      mem_ready = q[i].mr;
      zero      = q[i].z;
      op        = q[i].live ? o : 7'($urandom);
      #1;
      check_eq(kind_name(q[i].kind), 32'(act), 32'(exp_ctrl(q[i].kind, q[i].mr, q[i].z)));
    end
  endtask

  task automatic check_enables_low(input string tag);
    check_eq(tag, 32'({pc_write, ir_write, mem_write, reg_write, illegal_instr}), 32'd0);
  endtask

  initial begin
    logic [6:0] legal_ops [6];
    logic [6:0] o;
    legal_ops = '{TLoad, TStore, TRtype, TItype, TBranch, TJal};

    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; op = TRtype;
    repeat (3) @(negedge clk);
    #1 check_enables_low("reset_mr1");
    mem_ready = 1'b0;
    #1 check_enables_low("reset_mr0");
    rst_n = 1'b1;

    // Directed cases: R, lw with 3 wait cycles, sw, I, beq taken/not, jal, illegal.
    run_instr(TRtype, 0, 0, 1'b0, -1);
    run_instr(TLoad, 0, 3, 1'b0, -1);
    run_instr(TStore, 1, 2, 1'b0, -1);
    run_instr(TItype, 0, 0, 1'b0, -1);
    run_instr(TBranch, 0, 0, 1'b1, -1);
    run_instr(TBranch, 0, 0, 1'b0, -1);
    run_instr(TJal, 0, 0, 1'b0, -1);
    run_instr(7'b1111111, 0, 0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do o = 7'($urandom);
        while (o inside {TLoad, TStore, TRtype, TItype, TBranch, TJal});
      end else begin
        o = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), -1);
    end

    // Abort a store while it waits on memory, mid-cycle.
    run_instr(TStore, 0, 5, 1'b0, 4);
    rst_n = 1'b0;
    #1 check_eq("rst_abort_mem_write", 32'(mem_write), 32'd0);
    check_enables_low("rst_abort_en");
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check_enables_low("rst_hold_mr1");
    mem_ready = 1'b0;
    rst_n = 1'b1;
    run_instr(TLoad, 0, 0, 1'b0, -1);
    run_instr(TRtype, 0, 1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
